led_pattern_gen: RTL and testbench

- Multi-channel LED driver and the parametrised successor to the single-output blinker.
- Each channel is independently programmed through a valid/ready config port:
  - a mode: off, on, continuous blink, or burst of N blinks;
  - a period;
  - a duty (on-time).
- Sits between board bring-up control logic (or a UART/CSR front end) and the board LED pins.
- Reports per-channel activity and a pulse when a burst finishes.

---
 rtl/led_pkg.sv | 26 ++
 rtl/led_channel.sv | 127 ++++++++++++
 rtl/led_pattern_gen.sv | 64 ++++++
 tb/tb_led_pattern_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED pattern generator:
// mode encodings, per-channel state enum and default widths.
package led_pkg;

   localparam int DEF_NUM_CH  = 4;
   localparam int DEF_CNT_W   = 24;
   localparam int DEF_BURST_W = 8;
   localparam int DEF_CH_W    = 2;

   // Encoding of the cfg_mode field.
   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BURST = 2'd3
   } mode_e;

   // Per-channel FSM states. DONE lasts one cycle and then falls back to OFF.
   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_ON   = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } ch_state_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: latched configuration, phase counter, burst counter
// and the OFF/ON/RUN/DONE state machine. All outputs are registered and
// reflect the state held before the edge, so a commit at edge T shows on
// the outputs at edge T+1.
module led_channel
   import led_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int BURST_W = DEF_BURST_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               commit_i,
   input  mode_e              mode_i,
   input  logic [CNT_W-1:0]   period_i,
   input  logic [CNT_W-1:0]   duty_i,
   input  logic [BURST_W-1:0] count_i,
   output logic               led_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

   ch_state_e          state_q,  state_d;
   logic [CNT_W-1:0]   phase_q,  phase_d;
   logic [BURST_W-1:0] blink_q,  blink_d;
   logic               burst_q,  burst_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   duty_q,   duty_d;
   logic [BURST_W-1:0] count_q,  count_d;
   logic               led_q,    led_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;

   // Next-state logic: a commit overrides whatever the channel is doing,
   // otherwise RUN advances the phase and counts burst wraps.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      blink_d  = blink_q;
      burst_d  = burst_q;
      period_d = period_q;
      duty_d   = duty_q;
      count_d  = count_q;

      // Outputs follow the pre-edge state so new config appears one edge later.
      led_d  = (state_q == ST_ON) || ((state_q == ST_RUN) && (phase_q < duty_q));
      busy_d = (state_q == ST_RUN);
      done_d = (state_q == ST_DONE);

      if (commit_i) begin
         period_d = period_i;
         duty_d   = duty_i;
         count_d  = count_i;
         burst_d  = (mode_i == MODE_BURST);
         phase_d  = '0;
         blink_d  = '0;
         case (mode_i)
            MODE_OFF: state_d = ST_OFF;
            MODE_ON:  state_d = ST_ON;
            default: begin
               // A zero period cannot blink; a zero-length burst completes at once.
               if (period_i == '0) begin
                  state_d = ST_OFF;
               end else if ((mode_i == MODE_BURST) && (count_i == '0)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         endcase
      end else begin
         case (state_q)
            ST_RUN: begin
               // Compare against period-1 so the counter never reaches 2**CNT_W.
               if (phase_q == period_q - CNT_ONE) begin
                  phase_d = '0;
                  if (burst_q) begin
                     if (blink_q == count_q - BURST_ONE) begin
                        state_d = ST_DONE;
                     end
                     blink_d = blink_q + BURST_ONE;
                  end
               end else begin
                  phase_d = phase_q + CNT_ONE;
               end
            end
            ST_DONE: state_d = ST_OFF;
            default: ;
         endcase
      end
   end

   // State, config and output registers; reset drops everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_OFF;
         phase_q  <= '0;
         blink_q  <= '0;
         burst_q  <= 1'b0;
         period_q <= '0;
         duty_q   <= '0;
         count_q  <= '0;
         led_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         blink_q  <= blink_d;
         burst_q  <= burst_d;
         period_q <= period_d;
         duty_q   <= duty_d;
         count_q  <= count_d;
         led_q    <= led_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign led_o  = led_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: config handshake with a one-cycle
// commit gap, channel decode, and one led_channel per output.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int BURST_W = DEF_BURST_W,
   parameter int CH_W    = DEF_CH_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [1:0]         cfg_mode,
   input  logic [CNT_W-1:0]   cfg_period,
   input  logic [CNT_W-1:0]   cfg_duty,
   input  logic [BURST_W-1:0] cfg_count,
   output logic [NUM_CH-1:0]  led,
   output logic [NUM_CH-1:0]  busy,
   output logic [NUM_CH-1:0]  done
);

   logic ready_q, ready_d;
   logic accept;

   assign accept    = cfg_valid && ready_q;
   assign cfg_ready = ready_q;
   // Ready drops for exactly the cycle following an accept.
   assign ready_d   = !accept;

   // Handshake register; comes up 0 in reset and rises on the first edge after.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= ready_d;
      end
   end

   // Channel numbers >= NUM_CH match no instance, so such configs are
   // accepted by the handshake and otherwise dropped.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         led_channel #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
         ) u_channel (
            .clk      (clk),
            .rst_n    (reset),
            .commit_i (accept && (cfg_ch == CH_W'(gi))),
            .mode_i   (mode_e'(cfg_mode)),
            .period_i (cfg_period),
            .duty_i   (cfg_duty),
            .count_i  (cfg_count),
            .led_o    (led[gi]),
            .busy_o   (busy[gi]),
            .done_o   (done[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a table of single-channel configs
// with 32-cycle expected led/busy/done traces, plus hand-written sequences
// for long blinking, back-to-back accepts, mid-run abort and async reset.
module tb_led_pattern_gen;
   import led_pkg::*;

   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 24;
   localparam int BURST_W = 8;
   localparam int CH_W    = 2;

   logic               clk;
   logic               reset;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [CH_W-1:0]    cfg_ch;
   logic [1:0]         cfg_mode;
   logic [CNT_W-1:0]   cfg_period;
   logic [CNT_W-1:0]   cfg_duty;
   logic [BURST_W-1:0] cfg_count;
   logic [NUM_CH-1:0]  led;
   logic [NUM_CH-1:0]  busy;
   logic [NUM_CH-1:0]  done;

   int tests = 0;
   int fails = 0;

   led_pattern_gen #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W),
      .CH_W    (CH_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .cfg_count  (cfg_count),
      .led        (led),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit k of each expected trace is the output sampled just after edge T+1+k.
   typedef struct {
      logic [1:0]         ch;
      logic [1:0]         mode;
      logic [CNT_W-1:0]   period;
      logic [CNT_W-1:0]   duty;
      logic [BURST_W-1:0] count;
      logic [31:0]        exp_led;
      logic [31:0]        exp_busy;
      logic [31:0]        exp_done;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         $display("[TB] ok %s = 0x%08h", name, act);
      end
   endtask

   // Drive one config and return 1 ns after the accepting edge T.
   task automatic do_commit(input logic [1:0] ch, input logic [1:0] mode,
                            input logic [CNT_W-1:0] per, input logic [CNT_W-1:0] dty,
                            input logic [BURST_W-1:0] cnt);
      int guard;
      @(negedge clk);
      cfg_valid  = 1'b1;
      cfg_ch     = ch;
      cfg_mode   = mode;
      cfg_period = per;
      cfg_duty   = dty;
      cfg_count  = cnt;
      guard = 0;
      while (cfg_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         tests++;
         fails++;
         $display("[TB] FAIL commit timeout: cfg_ready got %b, expected 1", cfg_ready);
      end
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      $display("[TB] commit ch%0d mode=%0d period=%0d duty=%0d count=%0d", ch, mode, per, dty, cnt);
   endtask

   initial begin
      logic [31:0] cap_led, cap_busy, cap_done;
      int          rises;
      logic        prev, busy_all, done_seen, led1_hold, led_any, done_any;

      vecs[0] = '{2'd0, MODE_BLINK, 24'd10, 24'd3,  8'd0, 32'hC0701C07, 32'hFFFFFFFF, 32'h00000000};
      vecs[1] = '{2'd1, MODE_BURST, 24'd4,  24'd2,  8'd5, 32'h00033333, 32'h000FFFFF, 32'h00100000};
      vecs[2] = '{2'd2, MODE_BURST, 24'd5,  24'd2,  8'd0, 32'h00000000, 32'h00000000, 32'h00000001};
      vecs[3] = '{2'd3, MODE_BLINK, 24'd0,  24'd5,  8'd0, 32'h00000000, 32'h00000000, 32'h00000000};
      vecs[4] = '{2'd3, MODE_BLINK, 24'd8,  24'd12, 8'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      vecs[5] = '{2'd3, MODE_OFF,   24'd8,  24'd12, 8'd0, 32'h00000000, 32'h00000000, 32'h00000000};
      vecs[6] = '{2'd2, MODE_ON,    24'd0,  24'd0,  8'd0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      vecs[7] = '{2'd0, MODE_BLINK, 24'd3,  24'd0,  8'd0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
      vecs[8] = '{2'd1, MODE_BURST, 24'd1,  24'd1,  8'd3, 32'h00000007, 32'h00000007, 32'h00000008};
      vecs[9] = '{2'd0, MODE_BURST, 24'd3,  24'd5,  8'd2, 32'h0000003F, 32'h0000003F, 32'h00000040};

      cfg_valid  = 1'b0;
      cfg_ch     = '0;
      cfg_mode   = '0;
      cfg_period = '0;
      cfg_duty   = '0;
      cfg_count  = '0;
      reset      = 1'b0;

      // Reset held with the clock running.
      repeat (3) @(negedge clk);
      check("reset led",   32'(led),       32'h0);
      check("reset busy",  32'(busy),      32'h0);
      check("reset done",  32'(done),      32'h0);
      check("reset ready", 32'(cfg_ready), 32'h0);
      reset = 1'b1;
      #1;
      check("ready before first edge", 32'(cfg_ready), 32'h0);
      @(posedge clk);
      #1;
      check("ready after first edge", 32'(cfg_ready), 32'h1);

      // Table of single-channel configs.
      for (int i = 0; i < 10; i++) begin
         do_commit(vecs[i].ch, vecs[i].mode, vecs[i].period, vecs[i].duty, vecs[i].count);
         for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            cap_led[k]  = led[vecs[i].ch];
            cap_busy[k] = busy[vecs[i].ch];
            cap_done[k] = done[vecs[i].ch];
         end
         check($sformatf("vec%0d led",  i), cap_led,  vecs[i].exp_led);
         check($sformatf("vec%0d busy", i), cap_busy, vecs[i].exp_busy);
         check($sformatf("vec%0d done", i), cap_done, vecs[i].exp_done);
      end

      // Long BLINK on ch0: 1000 cycles of period 10 give 100 rising edges.
      do_commit(2'd0, MODE_OFF, 24'd0, 24'd0, 8'd0);
      do_commit(2'd0, MODE_BLINK, 24'd10, 24'd3, 8'd0);
      rises    = 0;
      prev     = 1'b0;
      busy_all = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         @(posedge clk);
         #1;
         if (led[0] === 1'b1 && prev === 1'b0) rises++;
         prev = led[0];
         if (busy[0] !== 1'b1) busy_all = 1'b0;
      end
      check("blink 1000 rising edges", 32'(rises), 32'd100);
      check("blink 1000 busy held", 32'(busy_all), 32'h1);

      // Mid-run abort of a BURST plus two accepts on consecutive cycles.
      done_seen = 1'b0;
      do_commit(2'd1, MODE_BURST, 24'd4, 24'd2, 8'd10);
      repeat (12) begin
         @(posedge clk);
         #1;
         done_seen |= done[1];
      end
      @(negedge clk);
      cfg_valid  = 1'b1;
      cfg_ch     = 2'd1;
      cfg_mode   = MODE_ON;
      cfg_period = '0;
      cfg_duty   = '0;
      cfg_count  = '0;
      check("b2b ready before accept", 32'(cfg_ready), 32'h1);
      @(posedge clk);
      #1;
      check("b2b ready in commit cycle", 32'(cfg_ready), 32'h0);
      done_seen |= done[1];
      cfg_ch   = 2'd2;
      cfg_mode = MODE_OFF;
      @(posedge clk);
      #1;
      check("reconfig led1 at T+1", 32'(led[1]), 32'h1);
      check("b2b ready back", 32'(cfg_ready), 32'h1);
      done_seen |= done[1];
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      check("b2b second held, led2 on", 32'(led[2]), 32'h1);
      check("b2b second accepted", 32'(cfg_ready), 32'h0);
      done_seen |= done[1];
      @(posedge clk);
      #1;
      check("b2b second applied, led2 off", 32'(led[2]), 32'h0);
      led1_hold = 1'b1;
      repeat (40) begin
         @(posedge clk);
         #1;
         done_seen |= done[1];
         if (led[1] !== 1'b1) led1_hold = 1'b0;
      end
      check("aborted burst no done", 32'(done_seen), 32'h0);
      check("reconfig led1 held on", 32'(led1_hold), 32'h1);

      // Async reset in the middle of four running bursts.
      for (int c = 0; c < 4; c++) begin
         do_commit(2'(c), MODE_BURST, 24'd4, 24'd4, 8'd50);
      end
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("bursts running led",  32'(led),  32'hF);
      check("bursts running busy", 32'(busy), 32'hF);
      #2;
      reset = 1'b0;
      #1;
      check("async reset led",   32'(led),       32'h0);
      check("async reset busy",  32'(busy),      32'h0);
      check("async reset done",  32'(done),      32'h0);
      check("async reset ready", 32'(cfg_ready), 32'h0);
      repeat (2) @(negedge clk);
      reset    = 1'b1;
      led_any  = 1'b0;
      done_any = 1'b0;
      repeat (250) begin
         @(posedge clk);
         #1;
         if (led != '0) led_any = 1'b1;
         if (done != '0) done_any = 1'b1;
      end
      check("after reset no done", 32'(done_any), 32'h0);
      check("after reset led off", 32'(led_any),  32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
